// File: rtl/pdm_mic_capture.sv
// PDM microphone front end: generates the mic bit clock, counts ones over a
// boxcar window of DECIM bits and converts the count to a signed 8-bit sample.
module pdm_mic_capture #(
  parameter int CLK_HALF       = 16,
  parameter int DECIM          = 64,
  parameter int WARMUP_SAMPLES = 256
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       en_in,
  input  logic       pdm_data_in,
  input  logic       clear_clip_in,
  output logic       pdm_clk_out,
  output logic [7:0] sample_out,
  output logic       sample_valid_out,
  output logic       running_out,
  output logic       clip_out
);

  localparam int DIV_W     = $clog2(CLK_HALF);
  localparam int BIT_W     = $clog2(DECIM);
  localparam int ACC_W     = $clog2(DECIM) + 1;
  localparam int WARM_W    = (WARMUP_SAMPLES > 1) ? $clog2(WARMUP_SAMPLES) : 1;
  localparam int WARM_LAST = (WARMUP_SAMPLES > 0) ? WARMUP_SAMPLES - 1 : 0;

  localparam logic signed [9:0] HALF_S  = 10'(DECIM / 2);
  localparam logic signed [9:0] SCALE_S = 10'(256 / DECIM);

  typedef enum logic [1:0] {IDLE, WARMUP, RUN} state_e;

  state_e             state_q, state_d;
  logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
  logic               pdm_clk_q, pdm_clk_d;
  logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [ACC_W-1:0]   ones_acc_q, ones_acc_d;
  logic [WARM_W-1:0]  warm_cnt_q, warm_cnt_d;
  logic [7:0]         sample_q, sample_d;
  logic               valid_q, valid_d;
  logic               clip_q, clip_d;
  logic               sync1_q, sync2_q;

  logic [ACC_W-1:0]   ones;
  logic signed [9:0]  centered;
  logic signed [9:0]  scaled;
  logic [7:0]         sat;
  logic               saturating;

  // Conversion of the window count, including the bit captured this cycle.
  assign ones       = ones_acc_q + ACC_W'(sync2_q);
  assign centered   = $signed(10'(ones)) - HALF_S;
  assign scaled     = centered * SCALE_S;
  assign saturating = (scaled > 10'sd127);

  always_comb begin
    if (saturating)              sat = 8'h7F;
    else if (scaled < -10'sd128) sat = 8'h80;
    else                         sat = scaled[7:0];
  end

  // NOTE: every signal assigned here gets a default first so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    div_cnt_d  = div_cnt_q;
    pdm_clk_d  = pdm_clk_q;
    bit_cnt_d  = bit_cnt_q;
    ones_acc_d = ones_acc_q;
    warm_cnt_d = warm_cnt_q;
    sample_d   = sample_q;
    valid_d    = 1'b0;
    clip_d     = clip_q & ~clear_clip_in;

    if (!en_in) begin
      // Disable wins over everything; a partial window is thrown away.
      state_d    = IDLE;
      div_cnt_d  = '0;
      pdm_clk_d  = 1'b0;
      bit_cnt_d  = '0;
      ones_acc_d = '0;
      warm_cnt_d = '0;
    end else if (state_q == IDLE) begin
      state_d = (WARMUP_SAMPLES == 0) ? RUN : WARMUP;
    end else if (div_cnt_q != DIV_W'(CLK_HALF - 1)) begin
      div_cnt_d = div_cnt_q + DIV_W'(1);
    end else begin
      div_cnt_d = '0;
      pdm_clk_d = ~pdm_clk_q;
      // Capture on the cycle before the falling edge of the mic clock.
      if (pdm_clk_q) begin
        if (bit_cnt_q == BIT_W'(DECIM - 1)) begin
          bit_cnt_d  = '0;
          ones_acc_d = '0;
          if (state_q == RUN) begin
            sample_d = sat;
            valid_d  = 1'b1;
            if (saturating) clip_d = 1'b1;
          end else if (warm_cnt_q == WARM_W'(WARM_LAST)) begin
            state_d    = RUN;
            warm_cnt_d = '0;
          end else begin
            warm_cnt_d = warm_cnt_q + WARM_W'(1);
          end
        end else begin
          bit_cnt_d  = bit_cnt_q + BIT_W'(1);
          ones_acc_d = ones;
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q    <= IDLE;
      div_cnt_q  <= '0;
      pdm_clk_q  <= 1'b0;
      bit_cnt_q  <= '0;
      ones_acc_q <= '0;
      warm_cnt_q <= '0;
      sample_q   <= '0;
      valid_q    <= 1'b0;
      clip_q     <= 1'b0;
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_cnt_q  <= div_cnt_d;
      pdm_clk_q  <= pdm_clk_d;
      bit_cnt_q  <= bit_cnt_d;
      ones_acc_q <= ones_acc_d;
      warm_cnt_q <= warm_cnt_d;
      sample_q   <= sample_d;
      valid_q    <= valid_d;
      clip_q     <= clip_d;
      sync1_q    <= pdm_data_in;
      sync2_q    <= sync1_q;
    end
  end

  assign pdm_clk_out      = pdm_clk_q;
  assign sample_out       = sample_q;
  assign sample_valid_out = valid_q;
  assign running_out      = (state_q == RUN);
  assign clip_out         = clip_q;

endmodule

// File: tb/tb_pdm_mic_capture.sv
// Directed bench for pdm_mic_capture with CLK_HALF=4, DECIM=8, WARMUP_SAMPLES=2:
// one capture every 8 cycles, one sample window every 64 cycles.
module tb_pdm_mic_capture;

  logic       clk_in = 1'b0;
  logic       rst_in;
  logic       en_in;
  logic       clear_clip_in;
  logic       pdm_data_in;
  logic       pdm_clk_out;
  logic [7:0] sample_out;
  logic       sample_valid_out;
  logic       running_out;
  logic       clip_out;

  int n_checks = 0;
  int n_errors = 0;

  // Mic model: a repeating 8-bit pattern, advanced after each falling mic-clock edge.
  logic [7:0] pat = 8'h00;
  logic [2:0] idx = 3'd0;
  assign pdm_data_in = pat[idx];
  always @(negedge pdm_clk_out) idx = idx + 3'd1;

  always #5 clk_in = ~clk_in;

  pdm_mic_capture #(
    .CLK_HALF      (4),
    .DECIM         (8),
    .WARMUP_SAMPLES(2)
  ) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .en_in           (en_in),
    .pdm_data_in     (pdm_data_in),
    .clear_clip_in   (clear_clip_in),
    .pdm_clk_out     (pdm_clk_out),
    .sample_out      (sample_out),
    .sample_valid_out(sample_valid_out),
    .running_out     (running_out),
    .clip_out        (clip_out)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_in);
  endtask

  // Counts cycles until a valid strobe is seen (bounded by max_cycles).
  task automatic wait_valid(input int max_cycles, output int cycles);
    cycles = 0;
    do begin
      tick();
      cycles++;
    end while (!sample_valid_out && cycles < max_cycles);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_pdm"},     32'(pdm_clk_out),      32'h0);
    check({tag, "_sample"},  32'(sample_out),       32'h0);
    check({tag, "_valid"},   32'(sample_valid_out), 32'h0);
    check({tag, "_running"}, 32'(running_out),      32'h0);
    check({tag, "_clip"},    32'(clip_out),         32'h0);
  endtask

  initial begin
    int cyc;
    int strobes;

    rst_in        = 1'b1;
    en_in         = 1'b0;
    clear_clip_in = 1'b0;
    repeat (3) tick();
    check_all_zero("reset");

    // All-zero data: two warm-up windows then -128 at 3*64-63+... = cycle 193.
    pat    = 8'h00;
    en_in  = 1'b1;
    rst_in = 1'b0;
    wait_valid(400, cyc);
    check("zeros_first_valid_cycle", 32'(cyc), 32'd193);
    check("zeros_sample", 32'(sample_out), 32'h80);
    check("zeros_clip", 32'(clip_out), 32'h0);
    check("zeros_running", 32'(running_out), 32'h1);
    tick();
    check("zeros_strobe_one_cycle", 32'(sample_valid_out), 32'h0);
    wait_valid(200, cyc);
    check("zeros_spacing", 32'(cyc + 1), 32'd64);
    check("zeros_sample2", 32'(sample_out), 32'h80);

    // Alternating bits: 4 ones of 8 -> 0.
    pat = 8'h55;
    wait_valid(200, cyc);
    check("alt_spacing", 32'(cyc), 32'd64);
    check("alt_sample", 32'(sample_out), 32'h00);

    // Six ones of 8 -> (6-4)*32 = 64.
    pat = 8'hDB;
    wait_valid(200, cyc);
    check("six_sample", 32'(sample_out), 32'h40);
    check("six_clip", 32'(clip_out), 32'h0);

    // All ones -> saturate to 127 and set clip.
    pat = 8'hFF;
    wait_valid(200, cyc);
    check("ones_sample", 32'(sample_out), 32'h7F);
    check("ones_clip", 32'(clip_out), 32'h1);

    // Clear pulsed in the very cycle the next all-ones window completes: set wins.
    repeat (63) tick();
    clear_clip_in = 1'b1;
    tick();
    clear_clip_in = 1'b0;
    check("setclr_valid_aligned", 32'(sample_valid_out), 32'h1);
    check("setclr_clip_kept", 32'(clip_out), 32'h1);

    // Zeros data: clip stays until pulsed, then clears.
    pat = 8'h00;
    wait_valid(200, cyc);
    check("clipheld_sample", 32'(sample_out), 32'h80);
    check("clipheld_clip", 32'(clip_out), 32'h1);
    clear_clip_in = 1'b1;
    tick();
    clear_clip_in = 1'b0;
    check("clear_clip", 32'(clip_out), 32'h0);

    // Drop enable mid-window: IDLE next cycle, sample held, no strobes.
    repeat (20) tick();
    en_in = 1'b0;
    tick();
    check("drop_running", 32'(running_out), 32'h0);
    check("drop_pdm", 32'(pdm_clk_out), 32'h0);
    check("drop_valid", 32'(sample_valid_out), 32'h0);
    check("drop_sample_hold", 32'(sample_out), 32'h80);
    strobes = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (sample_valid_out) strobes++;
    end
    check("idle_no_strobe", 32'(strobes), 32'd0);
    check("idle_pdm_low", 32'(pdm_clk_out), 32'h0);

    // Re-enable with all-ones data: warm-up repeats.
    pat   = 8'hFF;
    en_in = 1'b1;
    repeat (100) tick();
    check("rewarm_running", 32'(running_out), 32'h0);
    check("rewarm_sample_hold", 32'(sample_out), 32'h80);
    wait_valid(200, cyc);
    check("rewarm_valid_cycle", 32'(cyc + 100), 32'd193);
    check("rewarm_sample", 32'(sample_out), 32'h7F);
    check("rewarm_clip", 32'(clip_out), 32'h1);

    // Asynchronous reset between edges: outputs clear before the next edge.
    repeat (10) tick();
    #2 rst_in = 1'b1;
    #1 check_all_zero("async_rst");
    tick();
    rst_in = 1'b0;
    // First edge leaves IDLE, the mic clock rises CLK_HALF=4 cycles after that.
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!pdm_clk_out && cyc < 50);
    check("restart_first_rise", 32'(cyc), 32'd5);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pdm_mic_capture.md
Name: pdm_mic_capture

Overview:
- Audio input front end. It is the capture-side counterpart to pwm_audio_stereo: it receives a 1-bit PDM stream from an external MEMS microphone instead of emitting a PWM bitstream.
- It generates the microphone bit clock and decimates the bitstream with a boxcar ones-counter.
- It emits signed 8-bit samples (same format as song/sine samples) with a one-cycle valid strobe at about 48.8 kHz.
- It sits beside the song ROM and sine source; the top selects its output into select_sound.

Parameters:
- CLK_HALF, 16, clk_in cycles per half period of pdm_clk_out. Default gives 3.125 MHz at 100 MHz; legal values ≥ 4.
- DECIM, 64, PDM bits per output sample. Power of 2, range 2..256.
- WARMUP_SAMPLES, 256, samples computed and discarded after enable (mic start-up). Legal values ≥ 0.

Ports:
- clk_in, input, 1, system clock (100 MHz).
- rst_in, input, 1, asynchronous active-high reset.
- en_in, input, 1, capture enable (level).
- pdm_data_in, input, 1, asynchronous mic data; double-flop synchronized internally.
- clear_clip_in, input, 1, one-cycle pulse that clears clip_out.
- pdm_clk_out, output, 1, mic bit clock.
- sample_out, output, 8, signed two's-complement sample; holds its value between strobes.
- sample_valid_out, output, 1, one-cycle strobe when sample_out updates.
- running_out, output, 1, high while in RUN state.
- clip_out, output, 1, sticky saturation flag.

Behaviour:
- Reset (async, active-high): state=IDLE, pdm_clk_out=0, sample_out=0, sample_valid_out=0, running_out=0, clip_out=0, all counters and sync flops cleared.
- FSM states: IDLE, WARMUP, RUN.
  - IDLE→WARMUP when en_in=1. If WARMUP_SAMPLES=0, IDLE→RUN directly.
  - WARMUP→RUN on the cycle the WARMUP_SAMPLES-th sample completes.
  - Any state→IDLE on the first cycle en_in=0. This takes priority over every other event.
  - On entering IDLE: pdm_clk_out=0 next cycle; div_cnt, bit_cnt, ones_acc and warm_cnt cleared; sample_out and clip_out hold. A partial window is discarded.
- Divider (active in WARMUP/RUN): div_cnt counts 0..CLK_HALF-1. At CLK_HALF-1, pdm_clk_out toggles and div_cnt returns to 0. The first edge of pdm_clk_out is rising, CLK_HALF cycles after leaving IDLE.
- Bit capture: on the cycle with div_cnt=CLK_HALF-1 and pdm_clk_out=1 (the cycle before the falling edge), take pdm_data_sync. This is the second sync stage, so pdm_data_in must be stable ≥3 clk_in cycles before that edge.
  - One bit is captured every 2*CLK_HALF cycles.
  - ones_acc accumulates captured bits; width clog2(DECIM)+1.
  - bit_cnt counts 0..DECIM-1.
- Window complete: the capture with bit_cnt=DECIM-1.
  - ones = ones_acc + current bit, range 0..DECIM.
  - ones_acc and bit_cnt reset to 0 in the same cycle.
  - Sample period = 2*CLK_HALF*DECIM cycles (2048 by default).
- Conversion (10-bit signed intermediate):
  - centered = ones − DECIM/2.
  - scaled = centered × (256/DECIM).
  - Saturate to [−128,127].
  - Only ones=DECIM can saturate (+128→127). When it does, clip_out is set.
- Output: in RUN, sample_out is registered and sample_valid_out=1 on the cycle after window complete; otherwise sample_valid_out=0.
- Warm-up: in WARMUP, completed samples increment warm_cnt only. sample_out, valid and clip are untouched.
- running_out = (state==RUN).
- clip_out:
  - Set has priority over clear_clip_in in the same cycle.
  - Cleared only by clear_clip_in or reset.
  - Not cleared by en_in.
- Reset mid-window: everything returns to reset values asynchronously; no valid strobe is emitted.

Test Plan:
- Parameters CLK_HALF=4, DECIM=8, WARMUP_SAMPLES=2: en_in=1, pdm_data_in=1 constant → no valid for the first 2 windows (2×64 cycles); the third window yields sample_out=127, sample_valid_out one cycle, clip_out=1, running_out=1.
- Same parameters, pdm_data_in=0 → after warm-up, each strobe gives sample_out=−128; clip_out stays 0. Strobes are spaced exactly 64 cycles apart.
- Alternating bits per capture (4 ones of 8) → sample_out=0. Pattern with 6 ones → (6−4)×32=64.
- clip_out set, then clear_clip_in pulsed with an all-ones window completing in the same cycle → clip_out stays 1. Pulse clear_clip_in again with zeros data → clip_out=0.
- Drop en_in mid-window in RUN → next cycle state=IDLE, pdm_clk_out=0, no strobe, sample_out holds its last value. Re-enable → warm-up repeats (2 windows discarded).
- Assert rst_in asynchronously between clock edges mid-RUN → all outputs are 0 immediately, before the next clk_in edge. Release rst_in with en_in=1 → first pdm_clk_out rising edge CLK_HALF cycles later.
